rv32_pmp_csr_ctrl: RTL

- Owns the PMP configuration state (pmpcfg0-3, pmpaddr0-15) and serves machine-mode CSR accesses to them over a valid/ready handshake with 1-cycle response.
- Enforces the lock rules and the WARL field rules.
- Runs a multi-cycle scrub sequencer that clears unlocked regions.
- Drives the CSR shared bus consumed by the MPU checker.

---
 rtl/rv32_pmp_pkg.sv | 31 +++
 rtl/rv32_pmp_cfg_warl.sv | 21 ++
 rtl/rv32_pmp_csr_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pmp_pkg.sv
// Shared PMP definitions: address-match modes, CSR numbers, cfg bit positions, CSR op encoding.
// Used by rv32_pmp_csr_ctrl and rv32_pmp_cfg_warl.
package rv32_pmp_pkg;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } addr_match_e;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_RW   = 2'd1,
    OP_RS   = 2'd2,
    OP_RC   = 2'd3
  } csr_op_e;

  localparam logic [11:0] PMPCFG0  = 12'h3A0;
  localparam logic [11:0] PMPADDR0 = 12'h3B0;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  localparam int NB_PMP_MAX = 16;

endpackage

// File: rtl/rv32_pmp_cfg_warl.sv
// One pmpcfg byte lane: returns the byte that is actually stored for a write attempt,
// applying the reserved-bit and R=0/W=1 legalisation, or holding the old byte when locked.
module rv32_pmp_cfg_warl
  import rv32_pmp_pkg::*;
(
  input  logic [7:0] old_cfg,
  input  logic [7:0] new_cfg,
  input  logic       lock,
  output logic [7:0] cfg_out
);

  logic [7:0] legal;

  always_comb begin
    legal       = new_cfg;
    legal[6:5]  = 2'b00;
    if (!legal[CFG_R] && legal[CFG_W]) legal[CFG_W] = 1'b0;
    cfg_out     = lock ? old_cfg : legal;
  end

endmodule

// File: rtl/rv32_pmp_csr_ctrl.sv
// PMP CSR owner: pmpcfg0-3 / pmpaddr0-15 access with lock + WARL rules, scrub sequencer, MPU shared bus.
// Optional `PMP_LOCK_STATUS_EN adds lock_viol / lock_viol_sticky outputs.
module rv32_pmp_csr_ctrl
  import rv32_pmp_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NB_PMP_REGION = 16,
  parameter int CSR_SB_W      = 20*XLEN
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                csr_valid,
  output logic                csr_ready,
  input  logic [11:0]         csr_addr,
  input  logic [1:0]          csr_op,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic                csr_done,
  output logic                csr_hit,
  output logic [XLEN-1:0]     csr_rdata,
  input  logic                scrub_req,
  output logic                scrub_busy,
  output logic                scrub_done,
  output logic [CSR_SB_W-1:0] csr_sb
`ifdef PMP_LOCK_STATUS_EN
  ,
  output logic                lock_viol,
  output logic                lock_viol_sticky
`endif
);

  typedef enum logic {ST_IDLE, ST_SCRUB} state_e;

  state_e          state;
  logic [3:0]      idx;
  logic            scrub_pending;
  logic [7:0]      cfg_q  [NB_PMP_MAX];
  logic [XLEN-1:0] addr_q [NB_PMP_MAX];

  logic            accept, hit_cfg, hit_addr, is_write;
  csr_op_e         op;
  logic [XLEN-1:0] old_val, new_val;
  logic [NB_PMP_MAX:0]   tor_top_lock;
  logic [NB_PMP_MAX-1:0] addr_lock, cfg_we, addr_we;
  logic [7:0]      cfg_nb    [NB_PMP_MAX];
  logic [7:0]      cfg_legal [NB_PMP_MAX];
  logic [XLEN-1:0] addr_nd   [NB_PMP_MAX];

  function automatic logic [XLEN-1:0] csr_apply(input csr_op_e o, input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] wd);
    case (o)
      OP_RW:   return wd;
      OP_RS:   return old | wd;
      OP_RC:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  assign op         = csr_op_e'(csr_op);
  assign csr_ready  = (state == ST_IDLE);
  assign scrub_busy = (state == ST_SCRUB);
  assign accept     = csr_valid && csr_ready;
  assign hit_cfg    = (csr_addr[11:2] == PMPCFG0[11:2]);
  assign hit_addr   = (csr_addr[11:4] == PMPADDR0[11:4]);
  assign is_write   = (op != OP_READ);

  // A locked TOR entry i+1 also protects pmpaddr i (its base); lanes use live cfg state.
  always_comb begin
    tor_top_lock = '0;
    for (int i = 0; i < NB_PMP_MAX; i++)
      tor_top_lock[i] = cfg_q[i][CFG_L] && (cfg_q[i][CFG_A_HI:CFG_A_LO] == A_TOR);
    for (int i = 0; i < NB_PMP_MAX; i++)
      addr_lock[i] = cfg_q[i][CFG_L] || tor_top_lock[i+1];
  end

  always_comb begin
    old_val = '0;
    if (hit_cfg) begin
      for (int b = 0; b < 4; b++) old_val[8*b +: 8] = cfg_q[{csr_addr[1:0], 2'(b)}];
    end else if (hit_addr) begin
      old_val = addr_q[csr_addr[3:0]];
    end
    new_val = csr_apply(op, old_val, csr_wdata);
  end

  // Lane write requests: scrub clears lane idx, a CSR write targets its byte/word lanes.
  always_comb begin
    cfg_we  = '0;
    addr_we = '0;
    for (int i = 0; i < NB_PMP_MAX; i++) begin
      cfg_nb[i]  = 8'h00;
      addr_nd[i] = '0;
    end
    if (state == ST_SCRUB) begin
      cfg_we[idx]  = 1'b1;
      addr_we[idx] = 1'b1;
    end else if (accept && is_write) begin
      if (hit_cfg) begin
        for (int b = 0; b < 4; b++) begin
          cfg_we[{csr_addr[1:0], 2'(b)}] = 1'b1;
          cfg_nb[{csr_addr[1:0], 2'(b)}] = new_val[8*b +: 8];
        end
      end
      if (hit_addr) begin
        addr_we[csr_addr[3:0]] = 1'b1;
        addr_nd[csr_addr[3:0]] = new_val;
      end
    end
  end

  for (genvar g = 0; g < NB_PMP_MAX; g++) begin : g_lane
    rv32_pmp_cfg_warl u_warl (
      .old_cfg (cfg_q[g]),
      .new_cfg (cfg_nb[g]),
      .lock    (cfg_q[g][CFG_L]),
      .cfg_out (cfg_legal[g])
    );
    assign csr_sb[8*g +: 8]                 = cfg_q[g];
    assign csr_sb[4*XLEN + g*XLEN +: XLEN]  = addr_q[g];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NB_PMP_MAX; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_PMP_MAX; i++) begin
        if (cfg_we[i] && i < NB_PMP_REGION) cfg_q[i] <= cfg_legal[i];
        if (addr_we[i] && !addr_lock[i] && i < NB_PMP_REGION) addr_q[i] <= addr_nd[i];
      end
    end
  end

  // Response stage and scrub sequencer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      scrub_pending <= 1'b0;
      scrub_done    <= 1'b0;
      csr_done      <= 1'b0;
      csr_hit       <= 1'b0;
      csr_rdata     <= '0;
    end else begin
      csr_done   <= accept;
      csr_hit    <= accept && (hit_cfg || hit_addr);
      csr_rdata  <= accept ? old_val : '0;
      scrub_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scrub_pending || (scrub_req && !csr_valid)) begin
            state         <= ST_SCRUB;
            idx           <= '0;
            scrub_pending <= 1'b0;
          end else if (scrub_req) begin
            scrub_pending <= 1'b1;
          end
        end
        ST_SCRUB: begin
          if (idx == 4'(NB_PMP_REGION-1)) begin
            state      <= ST_IDLE;
            scrub_done <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PMP_LOCK_STATUS_EN
  logic viol;

  // RW to a locked lane always counts; RS/RC only when it would have changed the lane.
  always_comb begin
    viol = 1'b0;
    if (accept && is_write) begin
      for (int i = 0; i < NB_PMP_MAX; i++) begin
        if (cfg_we[i] && cfg_q[i][CFG_L] && (op == OP_RW || cfg_nb[i] != cfg_q[i]))
          viol = 1'b1;
        if (addr_we[i] && addr_lock[i] && (op == OP_RW || addr_nd[i] != addr_q[i]))
          viol = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lock_viol        <= 1'b0;
      lock_viol_sticky <= 1'b0;
    end else begin
      lock_viol        <= viol;
      lock_viol_sticky <= lock_viol_sticky | viol;
    end
  end
`endif

endmodule
